// File: rtl/mmio_bus_arbiter.sv
// Round-robin arbiter/sequencer for two masters sharing the switch/LED MMIO bus.
// Optional MMIO_ERR_EN: report decode errors on mN_err for unmapped accesses.
module mmio_bus_arbiter #(
  parameter int                ADDR_W   = 30,
  parameter int                DATA_W   = 32,
  parameter logic [ADDR_W-1:0] SW_ADDR  = 'h0,
  parameter logic [ADDR_W-1:0] LED_ADDR = 'h4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic              m0_we,
  input  logic              m0_re,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic              m0_done,
  output logic [DATA_W-1:0] m0_rdata,
  output logic              m0_err,
  input  logic              m1_req,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic              m1_we,
  input  logic              m1_re,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic              m1_done,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              m1_err,
  output logic [ADDR_W-1:0] memAddress,
  output logic              writeEnable,
  output logic              readEnable,
  output logic [DATA_W-1:0] writeData,
  input  logic [DATA_W-1:0] switchReadData,
  input  logic [DATA_W-1:0] ledReadData
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t              state_q, state_d;
  logic                ptr_q, ptr_d;   // 1 favours M1 on contention
  logic                win_q, win_d;   // 1 when M1 owns the current transfer
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                we_q, we_d;
  logic                re_q, re_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   m0_rdata_q, m0_rdata_d;
  logic [DATA_W-1:0]   m1_rdata_q, m1_rdata_d;

  logic                mapped;
  logic                in_access;
  logic                in_resp;
  logic                grant_m1;
  logic [DATA_W-1:0]   bus_rdata;
  logic [1:0]          gnt_vec;
  logic [1:0]          done_vec;
  logic [1:0]          err_vec;

  assign mapped    = (addr_q == SW_ADDR) || (addr_q == LED_ADDR);
  assign in_access = (state_q == ACCESS);
  assign in_resp   = (state_q == RESP);

  // Writes (including we&re) and null transfers return zero, as do unmapped reads.
  always_comb begin
    bus_rdata = '0;
    if (re_q && !we_q) begin
      if (addr_q == SW_ADDR)       bus_rdata = switchReadData;
      else if (addr_q == LED_ADDR) bus_rdata = ledReadData;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      ptr_q      <= 1'b0;
      win_q      <= 1'b0;
      addr_q     <= '0;
      we_q       <= 1'b0;
      re_q       <= 1'b0;
      wdata_q    <= '0;
      m0_rdata_q <= '0;
      m1_rdata_q <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      win_q      <= win_d;
      addr_q     <= addr_d;
      we_q       <= we_d;
      re_q       <= re_d;
      wdata_q    <= wdata_d;
      m0_rdata_q <= m0_rdata_d;
      m1_rdata_q <= m1_rdata_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    win_d      = win_q;
    addr_d     = addr_q;
    we_d       = we_q;
    re_d       = re_q;
    wdata_d    = wdata_q;
    m0_rdata_d = m0_rdata_q;
    m1_rdata_d = m1_rdata_q;
    grant_m1   = m1_req && (!m0_req || ptr_q);
    case (state_q)
      IDLE: begin
        if (m0_req || m1_req) begin
          win_d   = grant_m1;
          addr_d  = grant_m1 ? m1_addr  : m0_addr;
          we_d    = grant_m1 ? m1_we    : m0_we;
          re_d    = grant_m1 ? m1_re    : m0_re;
          wdata_d = grant_m1 ? m1_wdata : m0_wdata;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (win_q) m1_rdata_d = bus_rdata;
        else       m0_rdata_d = bus_rdata;
        state_d = RESP;
      end
      RESP: begin
        ptr_d   = ~win_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef MMIO_ERR_EN
  logic err_q, err_d;

  assign err_d = in_access ? (!mapped && (we_q || re_q)) : err_q;

  always_ff @(posedge clk) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= err_d;
  end
`endif

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_master
      assign gnt_vec[gi]  = in_access && (win_q == gi[0]);
      assign done_vec[gi] = in_resp   && (win_q == gi[0]);
`ifdef MMIO_ERR_EN
      assign err_vec[gi]  = done_vec[gi] && err_q;
`else
      assign err_vec[gi]  = 1'b0;
`endif
    end
  endgenerate

  assign m0_gnt      = gnt_vec[0];
  assign m1_gnt      = gnt_vec[1];
  assign m0_done     = done_vec[0];
  assign m1_done     = done_vec[1];
  assign m0_err      = err_vec[0];
  assign m1_err      = err_vec[1];
  assign m0_rdata    = m0_rdata_q;
  assign m1_rdata    = m1_rdata_q;
  assign memAddress  = addr_q;
  assign writeData   = wdata_q;
  assign writeEnable = in_access && we_q && mapped;
  assign readEnable  = in_access && re_q && !we_q && mapped;

endmodule

// File: tb/tb_mmio_bus_arbiter.sv
// Directed bench for mmio_bus_arbiter with a switch input and a simple LED register model.
module tb_mmio_bus_arbiter;
  logic        clk;
  logic        rst;
  logic        m0_req, m0_we, m0_re, m1_req, m1_we, m1_re;
  logic [29:0] m0_addr, m1_addr;
  logic [31:0] m0_wdata, m1_wdata;
  logic        m0_gnt, m0_done, m0_err, m1_gnt, m1_done, m1_err;
  logic [31:0] m0_rdata, m1_rdata;
  logic [29:0] memAddress;
  logic        writeEnable, readEnable;
  logic [31:0] writeData, switchReadData, ledReadData;
  logic [15:0] switches, leds;
  logic        exp_err;
  int          tests, fails, cyc, last_done;

  mmio_bus_arbiter dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_addr(m0_addr), .m0_we(m0_we), .m0_re(m0_re), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_done(m0_done), .m0_rdata(m0_rdata), .m0_err(m0_err),
    .m1_req(m1_req), .m1_addr(m1_addr), .m1_we(m1_we), .m1_re(m1_re), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_done(m1_done), .m1_rdata(m1_rdata), .m1_err(m1_err),
    .memAddress(memAddress), .writeEnable(writeEnable), .readEnable(readEnable),
    .writeData(writeData), .switchReadData(switchReadData), .ledReadData(ledReadData)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign switchReadData = {16'h0, switches};
  assign ledReadData    = {16'h0, leds};

  always @(posedge clk) begin
    if (rst) leds <= 16'h0;
    else if (writeEnable && memAddress == 30'h4) leds <= writeData[15:0];
  end

  task automatic tick;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  initial begin
    tests = 0; fails = 0; cyc = 0; last_done = 0;
`ifdef MMIO_ERR_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    rst = 1'b1; switches = 16'hA5A5;
    m0_req = 1'b1; m0_we = 1'b0; m0_re = 1'b1; m0_addr = 30'h0; m0_wdata = 32'h0;
    m1_req = 1'b0; m1_we = 1'b0; m1_re = 1'b0; m1_addr = 30'h0; m1_wdata = 32'h0;

    // 1. Reset held two cycles with m0_req high
    tick; tick;
    chk("rst_gnt0", m0_gnt, 1'b0);
    chk("rst_gnt1", m1_gnt, 1'b0);
    chk("rst_done0", m0_done, 1'b0);
    chk("rst_re", readEnable, 1'b0);
    chk("rst_addr", memAddress, 32'h0);
    chk("rst_rdata0", m0_rdata, 32'h0);
    rst = 1'b0;
    #1;
    chk("post_rst_idle_re", readEnable, 1'b0);

    // 2. M0 reads the switches
    tick;
    $display("[TB] txn M0 read 0x0");
    chk("m0rd_re", readEnable, 1'b1);
    chk("m0rd_we", writeEnable, 1'b0);
    chk("m0rd_addr", memAddress, 32'h0);
    chk("m0rd_gnt0", m0_gnt, 1'b1);
    chk("m0rd_gnt1", m1_gnt, 1'b0);
    tick;
    chk("m0rd_done", m0_done, 1'b1);
    chk("m0rd_rdata", m0_rdata, 32'h0000A5A5);
    chk("m0rd_err", m0_err, 1'b0);
    chk("m0rd_re_off", readEnable, 1'b0);
    chk("m0rd_done1", m1_done, 1'b0);
    m0_req = 1'b0;
    tick;
    chk("m0rd_done_pulse", m0_done, 1'b0);

    // we&re together is a write; readEnable must stay low
    m0_req = 1'b1; m0_we = 1'b1; m0_re = 1'b1; m0_addr = 30'h4; m0_wdata = 32'h1234;
    tick;
    $display("[TB] txn M0 write+read 0x4");
    chk("wr_re_we", writeEnable, 1'b1);
    chk("wr_re_re", readEnable, 1'b0);
    tick;
    chk("wr_re_done", m0_done, 1'b1);
    chk("wr_re_rdata", m0_rdata, 32'h0);
    chk("wr_re_leds", {16'h0, leds}, 32'h1234);
    m0_req = 1'b0; m0_we = 1'b0;
    tick;

    // 3. M1 write then read of the LED register
    m1_req = 1'b1; m1_we = 1'b1; m1_addr = 30'h4; m1_wdata = 32'h00000F0F;
    tick;
    $display("[TB] txn M1 write 0x4");
    chk("m1wr_we", writeEnable, 1'b1);
    chk("m1wr_wdata", writeData, 32'h00000F0F);
    chk("m1wr_addr", memAddress, 32'h4);
    chk("m1wr_gnt1", m1_gnt, 1'b1);
    chk("m1wr_gnt0", m0_gnt, 1'b0);
    tick;
    chk("m1wr_done", m1_done, 1'b1);
    chk("m1wr_we_off", writeEnable, 1'b0);
    chk("m1wr_leds", {16'h0, leds}, 32'h0F0F);
    chk("m1wr_rdata0_hold", m0_rdata, 32'h0);
    m1_we = 1'b0; m1_re = 1'b1;
    tick;
    chk("m1_idle_gnt", m1_gnt, 1'b0);
    tick;
    $display("[TB] txn M1 read 0x4");
    chk("m1rd_re", readEnable, 1'b1);
    tick;
    chk("m1rd_done", m1_done, 1'b1);
    chk("m1rd_rdata", m1_rdata, 32'h00000F0F);
    m1_req = 1'b0;
    tick;

    // 4. Contention: alternating grants, done every 3 cycles
    m0_req = 1'b1; m0_we = 1'b0; m0_re = 1'b1; m0_addr = 30'h0;
    m1_req = 1'b1; m1_we = 1'b0; m1_re = 1'b1; m1_addr = 30'h4;
    for (int k = 0; k < 4; k++) begin
      tick;
      $display("[TB] txn contention %0d", k);
      chk("cont_gnt0", m0_gnt, (k % 2) == 0);
      chk("cont_gnt1", m1_gnt, (k % 2) == 1);
      tick;
      chk("cont_done0", m0_done, (k % 2) == 0);
      chk("cont_done1", m1_done, (k % 2) == 1);
      if (k > 0) chk("cont_period", cyc - last_done, 3);
      last_done = cyc;
      tick;
    end
    m0_req = 1'b0; m1_req = 1'b0;
    chk("cont_rdata0", m0_rdata, 32'h0000A5A5);

    // 5. Unmapped read by M0
    m0_req = 1'b1; m0_addr = 30'h8;
    tick;
    $display("[TB] txn M0 read 0x8 (unmapped)");
    chk("unm_re", readEnable, 1'b0);
    chk("unm_we", writeEnable, 1'b0);
    chk("unm_gnt", m0_gnt, 1'b1);
    tick;
    chk("unm_done", m0_done, 1'b1);
    chk("unm_rdata", m0_rdata, 32'h0);
    chk("unm_err", m0_err, exp_err);
    m0_req = 1'b0;
    tick;
    chk("unm_err_pulse", m0_err, 1'b0);

    // Null transaction by M1 clears its rdata, no strobe, no error
    m1_req = 1'b1; m1_we = 1'b0; m1_re = 1'b0; m1_addr = 30'h0;
    tick;
    $display("[TB] txn M1 null");
    chk("null_re", readEnable, 1'b0);
    chk("null_we", writeEnable, 1'b0);
    tick;
    chk("null_done", m1_done, 1'b1);
    chk("null_rdata", m1_rdata, 32'h0);
    chk("null_err", m1_err, 1'b0);
    m1_req = 1'b0;
    tick;

    // 6. Reset during ACCESS after M0 was served (pointer favours M1 before reset)
    m0_req = 1'b1; m0_re = 1'b1; m0_addr = 30'h0;
    tick; tick;
    chk("pre_rst_done", m0_done, 1'b1);
    tick; tick;
    $display("[TB] txn M0 read aborted by reset");
    chk("pre_rst_gnt", m0_gnt, 1'b1);
    rst = 1'b1;
    tick;
    chk("mid_rst_done", m0_done, 1'b0);
    chk("mid_rst_gnt", m0_gnt, 1'b0);
    chk("mid_rst_re", readEnable, 1'b0);
    chk("mid_rst_rdata", m0_rdata, 32'h0);
    rst = 1'b0; m1_req = 1'b1; m1_re = 1'b1; m1_addr = 30'h4;
    tick;
    chk("post_rst_gnt0", m0_gnt, 1'b1);
    chk("post_rst_gnt1", m1_gnt, 1'b0);
    tick;
    chk("post_rst_done0", m0_done, 1'b1);
    m0_req = 1'b0; m1_req = 1'b0;
    tick;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
